// File: rtl/rv_mem_arbiter.sv
// Shares one memory port between IF fetch and MEM load/store; one transaction outstanding at a time.
// Latency: request seen in IDLE -> mem_req next cycle -> rvalid passed through combinationally on mem_rvalid.
// Backpressure: mem_req held until mem_ready; requesters stall via stall_if/stall_mem. Define ARB_STATS_EN for grant counters.
`default_nettype none

module rv_mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rvalid,
    output logic [XLEN-1:0]     if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [XLEN-1:0]     d_wdata,
    input  logic [XLEN/8-1:0]   d_wstrb,
    output logic                d_rvalid,
    output logic [XLEN-1:0]     d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                stall_if,
    output logic                stall_mem
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]         stat_if_grants,
    output logic [31:0]         stat_d_grants,
    output logic [31:0]         stat_conflicts
`endif
);

    localparam int         SW         = XLEN / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic       {OWN_FETCH, OWN_DATA} owner_t;

    state_t              state_q;
    owner_t              owner_q;
    logic [3:0]          starve_cnt_q;
    logic [3:0]          starve_cnt_d;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [XLEN-1:0]     mem_wdata_q;
    logic [SW-1:0]       mem_wstrb_q;

    logic                both_req;
    logic                starved;
    logic                pick_fetch;
    logic                rsp_hit;

    // Arbitration: data has priority unless fetch has lost too many times in a row
    always_comb begin
        both_req     = if_req & d_req;
        starved      = (starve_cnt_q >= STARVE_LIM);
        pick_fetch   = if_req & (~d_req | starved);
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE) begin
            if (pick_fetch) begin
                starve_cnt_d = 4'd0;
            end else if (both_req && starve_cnt_q != 4'hF) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    // Transaction FSM with registered memory-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_FETCH;
            starve_cnt_q <= 4'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
                        if (pick_fetch) begin
                            owner_q     <= OWN_FETCH;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                            mem_wstrb_q <= '1;
                        end else begin
                            owner_q     <= OWN_DATA;
                            mem_we_q    <= d_we;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                            mem_wstrb_q <= d_we ? d_wstrb : '1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state_q   <= WAIT;
                        mem_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Responses only count while a transaction is waiting; stray ones are dropped
    assign rsp_hit   = (state_q == WAIT) & mem_rvalid;
    assign if_rvalid = rsp_hit & (owner_q == OWN_FETCH);
    assign d_rvalid  = rsp_hit & (owner_q == OWN_DATA);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    assign stall_if  = if_req & ~if_rvalid;
    assign stall_mem = d_req & ~d_rvalid;

`ifdef ARB_STATS_EN
    logic [31:0] stat_if_grants_q;
    logic [31:0] stat_d_grants_q;
    logic [31:0] stat_conflicts_q;

    // Grant and conflict counters, updated on arbitration cycles only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_if_grants_q <= '0;
            stat_d_grants_q  <= '0;
            stat_conflicts_q <= '0;
        end else if (state_q == IDLE) begin
            if (pick_fetch) begin
                stat_if_grants_q <= stat_if_grants_q + 32'd1;
            end else if (d_req) begin
                stat_d_grants_q <= stat_d_grants_q + 32'd1;
            end
            if (both_req) begin
                stat_conflicts_q <= stat_conflicts_q + 32'd1;
            end
        end
    end

    assign stat_if_grants = stat_if_grants_q;
    assign stat_d_grants  = stat_d_grants_q;
    assign stat_conflicts = stat_conflicts_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: directed cycle table, starvation and reset sequences, randomized run against a transaction model.
// Cycle k inputs are driven 1 time unit after posedge k and outputs are sampled on the following negedge.
// Memory side is emulated with random ready/response delays and stray responses.
module tb_rv_mem_arbiter;

    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, mem_ready, mem_rvalid;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_wstrb;
    logic        if_rvalid, d_rvalid, mem_req, mem_we, stall_if, stall_mem;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
`ifdef ARB_STATS_EN
    logic [31:0] stat_if_grants, stat_d_grants, stat_conflicts;
`endif

    always #5 clk = ~clk;

    rv_mem_arbiter #(.XLEN(32), .ADDR_W(32), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef ARB_STATS_EN
        , .stat_if_grants(stat_if_grants), .stat_d_grants(stat_d_grants), .stat_conflicts(stat_conflicts)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req, d_we;
        logic [31:0] d_addr, d_wdata;
        logic [3:0]  d_wstrb;
        logic        mem_ready, mem_rvalid;
        logic [31:0] mem_rdata;
        logic        e_mem_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic        e_if_rv, e_d_rv;
    } vec_t;

    vec_t tbl[$];
    vec_t v;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dws,
                                input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic emr, input logic [31:0] ea, input logic ewe,
                                input logic [3:0] ews, input logic [31:0] ewd, input logic eirv, input logic edrv);
        vec_t r;
        r.if_req = ir; r.if_addr = ia; r.d_req = dr; r.d_we = dw; r.d_addr = da; r.d_wdata = dwd;
        r.d_wstrb = dws; r.mem_ready = rdy; r.mem_rvalid = rv; r.mem_rdata = rd;
        r.e_mem_req = emr; r.e_addr = ea; r.e_we = ewe; r.e_wstrb = ews; r.e_wdata = ewd;
        r.e_if_rv = eirv; r.e_d_rv = edrv;
        return r;
    endfunction

    task automatic zero_inputs();
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        d_wstrb = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk1({tag, " mem_req"}, mem_req, 1'b0);
        chk1({tag, " mem_we"}, mem_we, 1'b0);
        chk32({tag, " mem_addr"}, mem_addr, 32'h0);
        chk32({tag, " mem_wdata"}, mem_wdata, 32'h0);
        chk32({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'h0);
        chk1({tag, " if_rvalid"}, if_rvalid, 1'b0);
        chk1({tag, " d_rvalid"}, d_rvalid, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        zero_inputs();
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
`ifdef ARB_STATS_EN
        chk32("reset stat_if", stat_if_grants, 32'h0);
        chk32("reset stat_d", stat_d_grants, 32'h0);
        chk32("reset stat_conf", stat_conflicts, 32'h0);
`endif
        rst_n = 1'b1;
    endtask

    // Ten arbitrations with both requesters always present: fetch must win every (SL+1)-th time
    task automatic starvation_seq();
        int          dcnt;
        bit          exp_f;
        logic [31:0] ea;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            exp_f = ((i % (SL + 1)) == SL);
            ea    = exp_f ? 32'h100 : (32'h200 + 32'(dcnt * 4));
            @(posedge clk); #1;
            if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b1;
            d_addr = 32'h200 + 32'(dcnt * 4); d_wdata = $urandom; d_wstrb = 4'hF;
            mem_ready = 1'b1; mem_rvalid = 1'b0;
            @(negedge clk);
            @(posedge clk); #1;
            @(negedge clk);
            chk1($sformatf("starve%0d mem_req", i), mem_req, 1'b1);
            chk32($sformatf("starve%0d mem_addr", i), mem_addr, ea);
            @(posedge clk); #1;
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
            chk1($sformatf("starve%0d if_rvalid", i), if_rvalid, exp_f);
            chk1($sformatf("starve%0d d_rvalid", i), d_rvalid, !exp_f);
            if (!exp_f) dcnt++;
        end
        @(posedge clk); #1;
        zero_inputs();
`ifdef ARB_STATS_EN
        chk32("starve stat_if", stat_if_grants, 32'd2);
        chk32("starve stat_d", stat_d_grants, 32'd8);
        chk32("starve stat_conf", stat_conflicts, 32'd10);
`endif
    endtask

    // Reset pulsed while a fetch waits for its response, then a stray response arrives
    task automatic reset_mid_wait_seq();
        @(posedge clk); #1; if_req = 1'b1; if_addr = 32'h300;
        @(negedge clk);
        @(posedge clk); #1; mem_ready = 1'b1;
        @(negedge clk); chk1("rstw req", mem_req, 1'b1);
        @(posedge clk); #1; mem_ready = 1'b0; rst_n = 1'b0; if_req = 1'b0;
        @(negedge clk); check_idle_outputs("rstw in-reset");
        @(posedge clk); #1; rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h99;
        @(negedge clk); check_idle_outputs("rstw stray");
        @(posedge clk); #1; mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h304;
        @(negedge clk); chk1("rstw idle", mem_req, 1'b0);
        @(posedge clk); #1; mem_ready = 1'b1;
        @(negedge clk); chk1("rstw new req", mem_req, 1'b1); chk32("rstw new addr", mem_addr, 32'h304);
        @(posedge clk); #1; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
        @(negedge clk); chk1("rstw new rv", if_rvalid, 1'b1); chk32("rstw new rdata", if_rdata, 32'h77);
        @(posedge clk); #1; zero_inputs();
    endtask

    // Randomized traffic checked against a transaction-level model of the arbiter
    task automatic run_random(input int ncyc);
        bit          busy, accepted, own_fetch, e_if_rv, e_d_rv;
        int          starve, rdy_wait, rsp_wait;
        logic [31:0] t_addr, t_wdata;
        logic        t_we;
        logic [3:0]  t_wstrb;
        logic        n_ir, n_dr, n_dw, n_rdy, n_rv;
        logic [31:0] n_ia, n_da, n_dwd, n_rd;
        logic [3:0]  n_dws;
        busy = 0; accepted = 0; own_fetch = 0; starve = 0; rdy_wait = 0; rsp_wait = 0;
        t_addr = '0; t_wdata = '0; t_we = 1'b0; t_wstrb = '0;
        n_ir = 1'b0; n_dr = 1'b0; n_dw = 1'b0; n_rdy = 1'b0; n_rv = 1'b0;
        n_ia = '0; n_da = '0; n_dwd = '0; n_rd = '0; n_dws = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if_req = n_ir; if_addr = n_ia; d_req = n_dr; d_we = n_dw; d_addr = n_da;
            d_wdata = n_dwd; d_wstrb = n_dws; mem_ready = n_rdy; mem_rvalid = n_rv; mem_rdata = n_rd;
            @(negedge clk);
            e_if_rv = busy && accepted && mem_rvalid && own_fetch;
            e_d_rv  = busy && accepted && mem_rvalid && !own_fetch;
            chk1("rnd mem_req", mem_req, busy && !accepted);
            if (busy && !accepted) begin
                chk32("rnd mem_addr", mem_addr, t_addr);
                chk1("rnd mem_we", mem_we, t_we);
                chk32("rnd mem_wstrb", 32'(mem_wstrb), 32'(t_wstrb));
                if (t_we) chk32("rnd mem_wdata", mem_wdata, t_wdata);
            end
            chk1("rnd if_rvalid", if_rvalid, e_if_rv);
            chk1("rnd d_rvalid", d_rvalid, e_d_rv);
            if (e_if_rv) chk32("rnd if_rdata", if_rdata, mem_rdata);
            if (e_d_rv && !t_we) chk32("rnd d_rdata", d_rdata, mem_rdata);
            chk1("rnd stall_if", stall_if, if_req && !e_if_rv);
            chk1("rnd stall_mem", stall_mem, d_req && !e_d_rv);

            // Model step
            if (!busy) begin
                if (if_req || d_req) begin
                    own_fetch = if_req && (!d_req || starve >= SL);
                    if (own_fetch) starve = 0;
                    else if (if_req) starve = (starve < 15) ? starve + 1 : 15;
                    t_addr  = own_fetch ? if_addr : d_addr;
                    t_we    = own_fetch ? 1'b0 : d_we;
                    t_wstrb = (own_fetch || !d_we) ? 4'hF : d_wstrb;
                    t_wdata = d_wdata;
                    busy = 1; accepted = 0;
                    rdy_wait = $urandom_range(0, 3);
                end
            end else if (!accepted) begin
                if (mem_ready) begin
                    accepted = 1;
                    rsp_wait = $urandom_range(0, 2);
                end
            end else if (mem_rvalid) begin
                busy = 0;
            end

            // Requesters
            if (e_if_rv) begin
                if ($urandom_range(0, 9) < 7) n_ia = 32'($urandom_range(0, 1023)) << 2;
                else n_ir = 1'b0;
            end else if (!n_ir && $urandom_range(0, 9) < 4) begin
                n_ir = 1'b1; n_ia = 32'($urandom_range(0, 1023)) << 2;
            end
            if (e_d_rv && $urandom_range(0, 9) >= 7) begin
                n_dr = 1'b0;
            end else if (e_d_rv || (!n_dr && $urandom_range(0, 9) < 5)) begin
                n_dr = 1'b1; n_dw = 1'($urandom_range(0, 1));
                n_da = 32'($urandom_range(0, 1023)) << 2; n_dwd = $urandom;
                n_dws = 4'($urandom_range(0, 15));
            end

            // Memory
            if (busy && !accepted) begin
                if (rdy_wait == 0) n_rdy = 1'b1;
                else begin n_rdy = 1'b0; rdy_wait--; end
            end else begin
                n_rdy = 1'($urandom_range(0, 1));
            end
            if (busy && accepted) begin
                if (rsp_wait == 0) n_rv = 1'b1;
                else begin n_rv = 1'b0; rsp_wait--; end
            end else begin
                n_rv = ($urandom_range(0, 4) == 0);
            end
            n_rd = $urandom;
        end
        @(posedge clk); #1;
        zero_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        zero_inputs();

        // Fetch-only, stray response in IDLE
        tbl.push_back(mk('1, 32'h100, '0, '0, 32'h0, 32'h0, 4'h0, '0, '0, 32'h0,          '0, 32'h0, '0, 4'h0, 32'h0, '0, '0));
        tbl.push_back(mk('1, 32'h100, '0, '0, 32'h0, 32'h0, 4'h0, '1, '0, 32'h0,          '1, 32'h100, '0, 4'hF, 32'h0, '0, '0));
        tbl.push_back(mk('1, 32'h100, '0, '0, 32'h0, 32'h0, 4'h0, '0, '1, 32'h13,         '0, 32'h0, '0, 4'h0, 32'h0, '1, '0));
        tbl.push_back(mk('0, 32'h0,   '0, '0, 32'h0, 32'h0, 4'h0, '0, '1, 32'hBAD,        '0, 32'h0, '0, 4'h0, 32'h0, '0, '0));
        // Conflict: data load first, then fetch
        tbl.push_back(mk('1, 32'h104, '1, '0, 32'h200, 32'h55, 4'h0, '0, '0, 32'h0,       '0, 32'h0, '0, 4'h0, 32'h0, '0, '0));
        tbl.push_back(mk('1, 32'h104, '1, '0, 32'h200, 32'h55, 4'h0, '1, '0, 32'h0,       '1, 32'h200, '0, 4'hF, 32'h0, '0, '0));
        tbl.push_back(mk('1, 32'h104, '1, '0, 32'h200, 32'h55, 4'h0, '0, '1, 32'hAAAA5555, '0, 32'h0, '0, 4'h0, 32'h0, '0, '1));
        tbl.push_back(mk('1, 32'h104, '0, '0, 32'h0, 32'h0, 4'h0, '0, '0, 32'h0,          '0, 32'h0, '0, 4'h0, 32'h0, '0, '0));
        tbl.push_back(mk('1, 32'h104, '0, '0, 32'h0, 32'h0, 4'h0, '1, '0, 32'h0,          '1, 32'h104, '0, 4'hF, 32'h0, '0, '0));
        tbl.push_back(mk('1, 32'h104, '0, '0, 32'h0, 32'h0, 4'h0, '0, '1, 32'h12345678,   '0, 32'h0, '0, 4'h0, 32'h0, '1, '0));
        // Back-to-back fetches 0x0, 0x4, 0x8
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk('1, 32'(k * 4), '0, '0, 32'h0, 32'h0, 4'h0, '0, '0, 32'h0,  '0, 32'h0, '0, 4'h0, 32'h0, '0, '0));
            tbl.push_back(mk('1, 32'(k * 4), '0, '0, 32'h0, 32'h0, 4'h0, '1, '0, 32'h0,  '1, 32'(k * 4), '0, 4'hF, 32'h0, '0, '0));
            tbl.push_back(mk('1, 32'(k * 4), '0, '0, 32'h0, 32'h0, 4'h0, '0, '1, 32'(32'h11 * (k + 1)), '0, 32'h0, '0, 4'h0, 32'h0, '1, '0));
        end
        // Store with mem_ready held off 3 cycles, stray response while requesting
        tbl.push_back(mk('0, 32'h0, '1, '1, 32'h40, 32'hDEADBEEF, 4'h3, '0, '0, 32'h0, '0, 32'h0, '0, 4'h0, 32'h0, '0, '0));
        tbl.push_back(mk('0, 32'h0, '1, '1, 32'h40, 32'hDEADBEEF, 4'h3, '0, '0, 32'h0, '1, 32'h40, '1, 4'h3, 32'hDEADBEEF, '0, '0));
        tbl.push_back(mk('0, 32'h0, '1, '1, 32'h40, 32'hDEADBEEF, 4'h3, '0, '1, 32'h5, '1, 32'h40, '1, 4'h3, 32'hDEADBEEF, '0, '0));
        tbl.push_back(mk('0, 32'h0, '1, '1, 32'h40, 32'hDEADBEEF, 4'h3, '0, '0, 32'h0, '1, 32'h40, '1, 4'h3, 32'hDEADBEEF, '0, '0));
        tbl.push_back(mk('0, 32'h0, '1, '1, 32'h40, 32'hDEADBEEF, 4'h3, '1, '0, 32'h0, '1, 32'h40, '1, 4'h3, 32'hDEADBEEF, '0, '0));
        tbl.push_back(mk('0, 32'h0, '1, '1, 32'h40, 32'hDEADBEEF, 4'h3, '0, '0, 32'h0, '0, 32'h0, '0, 4'h0, 32'h0, '0, '0));
        tbl.push_back(mk('0, 32'h0, '1, '1, 32'h40, 32'hDEADBEEF, 4'h3, '0, '1, 32'hFFFF0000, '0, 32'h0, '0, 4'h0, 32'h0, '0, '1));
        tbl.push_back(mk('0, 32'h0, '0, '0, 32'h0, 32'h0, 4'h0, '0, '0, 32'h0,        '0, 32'h0, '0, 4'h0, 32'h0, '0, '0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(posedge clk); #1;
            if_req = v.if_req; if_addr = v.if_addr; d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr;
            d_wdata = v.d_wdata; d_wstrb = v.d_wstrb; mem_ready = v.mem_ready; mem_rvalid = v.mem_rvalid;
            mem_rdata = v.mem_rdata;
            @(negedge clk);
            chk1($sformatf("tbl%0d mem_req", i), mem_req, v.e_mem_req);
            if (v.e_mem_req) begin
                chk32($sformatf("tbl%0d mem_addr", i), mem_addr, v.e_addr);
                chk1($sformatf("tbl%0d mem_we", i), mem_we, v.e_we);
                chk32($sformatf("tbl%0d mem_wstrb", i), 32'(mem_wstrb), 32'(v.e_wstrb));
                if (v.e_we) chk32($sformatf("tbl%0d mem_wdata", i), mem_wdata, v.e_wdata);
            end
            chk1($sformatf("tbl%0d if_rvalid", i), if_rvalid, v.e_if_rv);
            chk1($sformatf("tbl%0d d_rvalid", i), d_rvalid, v.e_d_rv);
            if (v.e_if_rv) chk32($sformatf("tbl%0d if_rdata", i), if_rdata, v.mem_rdata);
            if (v.e_d_rv && !v.d_we) chk32($sformatf("tbl%0d d_rdata", i), d_rdata, v.mem_rdata);
            chk1($sformatf("tbl%0d stall_if", i), stall_if, v.if_req & ~v.e_if_rv);
            chk1($sformatf("tbl%0d stall_mem", i), stall_mem, v.d_req & ~v.e_d_rv);
        end
`ifdef ARB_STATS_EN
        chk32("tbl stat_if", stat_if_grants, 32'd5);
        chk32("tbl stat_d", stat_d_grants, 32'd2);
        chk32("tbl stat_conf", stat_conflicts, 32'd1);
`endif

        do_reset();
        starvation_seq();

        do_reset();
        reset_mid_wait_seq();

        do_reset();
        run_random(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
Single-port memory arbiter for the 5-stage RV32I pipeline. It shares one unified instruction/data memory port between the IF-stage fetch requester and the MEM-stage load/store requester. Only one transaction is outstanding at a time. It generates stall_if / stall_mem for the pipeline hazard logic and includes an anti-starvation mechanism for fetch.

Parameters:
XLEN, 32, data width of all data buses
ADDR_W, 32, byte-address width
STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch is forced to win (1..15)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
if_req  input  1  fetch request, level, held until if_rvalid
if_addr  input  ADDR_W  fetch byte address, stable while if_req
if_rvalid  output  1  one-cycle pulse, fetch data valid
if_rdata  output  XLEN  fetch data
d_req  input  1  data request, level, held until d_rvalid
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data byte address
d_wdata  input  XLEN  store data
d_wstrb  input  XLEN/8  store byte enables
d_rvalid  output  1  one-cycle pulse, load data valid or store complete
d_rdata  output  XLEN  load data
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  write enable
mem_addr  output  ADDR_W  memory address (registered)
mem_wdata  output  XLEN  write data (registered)
mem_wstrb  output  XLEN/8  byte enables (registered; all-ones for fetch and loads)
mem_ready  input  1  memory accepts request this cycle
mem_rvalid  input  1  response pulse (reads and writes)
mem_rdata  input  XLEN  read data
stall_if  output  1  if_req & ~if_rvalid
stall_mem  output  1  d_req & ~d_rvalid

Behaviour:
- FSM states: IDLE, REQ (mem_req=1), WAIT (accepted, awaiting mem_rvalid). An owner register (FETCH/DATA) is held alongside.
- Reset: state=IDLE, owner=FETCH, starve_cnt=0. mem_req, mem_we, if_rvalid, d_rvalid = 0. mem_addr, mem_wdata, mem_wstrb = 0.
- IDLE with any request: arbitrate and register addr/wdata/wstrb/we of the winner; next state REQ.
- Priority: data wins over fetch, except when starve_cnt >= STARVE_LIMIT, in which case fetch wins.
- starve_cnt: incremented (saturating at 15) when both requests are present and data wins. Cleared when fetch is granted.
- REQ: mem_req=1 with stable outputs. Advances to WAIT on the edge where mem_ready=1; stays in REQ otherwise.
- WAIT: on mem_rvalid, pulse if_rvalid or d_rvalid (according to owner) in the same cycle, combinationally. if_rdata/d_rdata = mem_rdata. Next state IDLE.
- mem_rvalid outside WAIT is ignored, including a stale response after reset.
- Minimum latency: request at cycle 0 → mem_req at cycle 1 → accepted at cycle 1 → rvalid earliest at cycle 2. Next arbitration at cycle 3.
- Requester protocol: req is sampled only in IDLE. After an rvalid pulse the requester must update or drop req before the next IDLE cycle; a held req starts a new transaction.
- Store completion: d_rvalid pulses; d_rdata is don't-care.
- Fetch: mem_we=0, mem_wstrb all-ones.
- Reset asserted mid-transaction: the transaction is abandoned and the FSM returns to IDLE immediately. No rvalid pulse is emitted.
- Simultaneous new requests with an rvalid pulse: no conflict, since arbitration happens only in IDLE.

Optional Feature:
ARB_STATS_EN
- Defined: adds three output ports, each 32 bits, wrapping, reset to 0:
  - stat_if_grants: fetch grants
  - stat_d_grants: data grants
  - stat_conflicts: IDLE cycles with both requests present
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Fetch-only: if_req=1, if_addr=0x100; memory returns ready in 0 wait cycles and rvalid 1 cycle later with data 0x00000013 → mem_req cycle 1 with addr 0x100, we=0; if_rvalid at cycle 2 with if_rdata=0x00000013; stall_if high for cycles 0-1.
2. Conflict: if_req and d_req (load 0x200) both asserted at cycle 0 → data granted first (mem_addr=0x200); fetch granted next; d_rvalid precedes if_rvalid; stat_conflicts=1 (if ARB_STATS_EN).
3. Starvation: d_req held with a new store every transaction while if_req=1, STARVE_LIMIT=4 → four data grants, then fetch granted on the 5th arbitration; starve_cnt clears.
4. Store with mem_ready delayed 3 cycles: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_wstrb=4'b0011 → mem_req and registered outputs stable for 4 cycles; d_rvalid pulses once on mem_rvalid.
5. Reset mid-WAIT: rst_n low for 1 cycle during WAIT, then a stray mem_rvalid arrives → no if_rvalid/d_rvalid; state IDLE; all outputs 0.
6. Back-to-back fetches: if_req held, addresses 0x0, 0x4, 0x8 → three transactions at 3-cycle spacing with correct data routing.
